sensor_input_conditioner: RTL

Conditions the six raw greenhouse sensor switches (S1, S2, H, T, L, M) before they reach the sensor/actuator logic and status display. Each channel is synchronised to clk by two flops and then debounced. The block emits clean levels, one-cycle rise and fall event pulses, and a ready flag. It sits between the board switch pins and the sensor-decision logic, which consumes sw_clean in place of raw sw.

---
 rtl/greenhouse_pkg.sv | 18 +
 rtl/debounce_channel.sv | 70 +++++++
 rtl/sensor_input_conditioner.sv | 67 ++++++
 3 files changed

// File: rtl/greenhouse_pkg.sv
// Shared constants for the greenhouse controller: sensor count, channel
// indices into the sensor vector, and the default debounce interval.
package greenhouse_pkg;

  // Sensor vector layout is [M L T H S2 S1], S1 at bit 0.
  localparam int N_SENSORS = 6;

  localparam int IDX_S1 = 0;
  localparam int IDX_S2 = 1;
  localparam int IDX_H  = 2;
  localparam int IDX_T  = 3;
  localparam int IDX_L  = 4;
  localparam int IDX_M  = 5;

  // 10 ms at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// One sensor bit: two-flop synchroniser, mismatch counter, debounced level
// and registered one-cycle rise/fall pulses. The clean level is preloaded
// from the synchroniser on the settle edge (load) and only tracks the input
// once enable is high.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  input  logic enable,
  input  logic load,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  logic             s1_reg;
  logic             s2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             clean_reg;
  logic             rise_reg;
  logic             fall_reg;

  // Two-flop synchroniser; only s2_reg is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= sw_raw;
      s2_reg <= s1_reg;
    end
  end

  // Debounce counter, clean level and edge pulses (pulses default low each cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      clean_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (load) begin
        // Settle edge: adopt the settled input silently, no pulse.
        clean_reg <= s2_reg;
        cnt_reg   <= '0;
      end else if (enable) begin
        if (s2_reg == clean_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          clean_reg <= s2_reg;
          cnt_reg   <= '0;
          rise_reg  <= s2_reg;
          fall_reg  <= ~s2_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign sw_clean = clean_reg;
  assign sw_rise  = rise_reg;
  assign sw_fall  = fall_reg;

endmodule

// File: rtl/sensor_input_conditioner.sv
// Conditions the raw greenhouse sensor switches: per-channel sync and
// debounce, a startup settle period that preloads the clean levels without
// generating events, and a combined changed pulse.
module sensor_input_conditioner
  import greenhouse_pkg::*;
#(
  parameter int N_CH            = N_SENSORS,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_clean,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            changed,
  output logic            ready
);

  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // Settle counter must be able to hold DEBOUNCE_CYCLES+2.
  localparam int SETTLE_W = $clog2(DEBOUNCE_CYCLES + 3);

  logic [SETTLE_W-1:0] settle_cnt_reg;
  logic                ready_reg;
  logic                settle_done;

  // The load edge is the one on which the settle count reaches DEBOUNCE_CYCLES+2.
  assign settle_done = ~ready_reg && (settle_cnt_reg == SETTLE_W'(DEBOUNCE_CYCLES + 1));

  // Startup settle counter; ready latches high until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_reg <= '0;
      ready_reg      <= 1'b0;
    end else if (~ready_reg) begin
      settle_cnt_reg <= settle_cnt_reg + 1'b1;
      if (settle_done) begin
        ready_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : gen_ch
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw[gi]),
        .enable  (ready_reg),
        .load    (settle_done),
        .sw_clean(sw_clean[gi]),
        .sw_rise (sw_rise[gi]),
        .sw_fall (sw_fall[gi])
      );
    end
  endgenerate

  // Pulses come straight from registers, so the OR is itself a clean one-cycle pulse.
  assign changed = |(sw_rise | sw_fall);
  assign ready   = ready_reg;

endmodule
